// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage-boundary registers.
// Stall counter width is used when PIPE_SKID_STALL_CNT_EN is defined.
package pipe_pkg;

    localparam int STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register for a valid/ready stage boundary.
// Define PIPE_SKID_STALL_CNT_EN to add the saturating stall_cnt output.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W        = 70,
    parameter bit ZERO_ON_EMPTY = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    pipe_state_t       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              accept;
    logic              pop;

    // Handshake outputs come from registered state only.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_d = in_data;
                    end else if (accept) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (pop) begin
                        state_d = EMPTY;
                        main_d  = ZERO_ON_EMPTY ? '0 : main_q;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = ZERO_ON_EMPTY ? '0 : skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_SKID_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_q;

    // Saturates; flush deliberately leaves the count alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg.
// Stall counter checks run when PIPE_SKID_STALL_CNT_EN is defined.
module tb_pipe_skid_reg;

    localparam int DW = 70;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
`ifdef PIPE_SKID_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] exp_q[$];

    pipe_skid_reg #(.DATA_W(DW), .ZERO_ON_EMPTY(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef PIPE_SKID_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        exp_q.push_back(d);
    endtask

    // Monitor: the handshake seen mid-cycle completes at the next edge.
    always @(negedge clk) begin
        if (!reset && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: got %0h expected none",
                         out_data);
            end else begin
                chk("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #2;
        chk("rst_occ", DW'(occupancy), 0);
        chk("rst_ovalid", DW'(out_valid), 0);
        chk("rst_iready", DW'(in_ready), 1);
        chk("rst_odata", out_data, 0);
        step();
        step();
        reset = 1'b0;

        // Single entry, one-cycle latency.
        out_ready = 1'b1;
        push(70'h5);
        step();
        in_valid = 1'b0;
        chk("one_occ", DW'(occupancy), 1);
        chk("one_ovalid", DW'(out_valid), 1);
        chk("one_odata", out_data, 70'h5);
        step();
        chk("drain_occ", DW'(occupancy), 0);
        chk("drain_odata", out_data, 0);

        // Fill to FULL, reject a third entry, drain in order.
        out_ready = 1'b0;
        push(70'h1);
        step();
        push(70'h2);
        step();
        chk("full_occ", DW'(occupancy), 2);
        chk("full_iready", DW'(in_ready), 0);
        chk("full_head", out_data, 70'h1);
        in_valid = 1'b1;
        in_data  = 70'h3;
        step();
        chk("reject_occ", DW'(occupancy), 2);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("pop1_occ", DW'(occupancy), 1);
        chk("pop1_data", out_data, 70'h2);
        step();
        chk("pop2_occ", DW'(occupancy), 0);
        chk("pop2_valid", DW'(out_valid), 0);
        chk("pop2_data", out_data, 0);

        // Flush beats a simultaneous push.
        out_ready = 1'b0;
        push(70'h11);
        step();
        push(70'h22);
        step();
        chk("pre_flush_occ", DW'(occupancy), 2);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 70'h9;
        exp_q.delete();
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_occ", DW'(occupancy), 0);
        chk("flush_valid", DW'(out_valid), 0);
        chk("flush_data", out_data, 0);
        chk("flush_iready", DW'(in_ready), 1);
        out_ready = 1'b1;
        step();
        step();
        chk("post_flush_valid", DW'(out_valid), 0);

        // Streaming at full rate.
        for (int i = 1; i <= 100; i++) begin
            push(DW'(i));
            step();
            chk("stream_occ", DW'(occupancy), 1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_end_occ", DW'(occupancy), 0);

        // Asynchronous reset while FULL.
        out_ready = 1'b0;
        push(70'h33);
        step();
        push(70'h44);
        step();
        in_valid = 1'b0;
        chk("pre_rst_occ", DW'(occupancy), 2);
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("arst_occ", DW'(occupancy), 0);
        chk("arst_valid", DW'(out_valid), 0);
        chk("arst_data", out_data, 0);
        chk("arst_iready", DW'(in_ready), 1);
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        push(70'h2A_BCDE_F012_3456_789A);
        step();
        in_valid = 1'b0;
        chk("after_rst_occ", DW'(occupancy), 1);
        chk("after_rst_data", out_data, 70'h2A_BCDE_F012_3456_789A);
        step();
        chk("after_rst_empty", DW'(occupancy), 0);

`ifdef PIPE_SKID_STALL_CNT_EN
        chk("stall_idle", DW'(stall_cnt), 0);
        out_ready = 1'b0;
        push(70'h77);
        step();
        in_valid = 1'b0;
        repeat (70000) step();
        chk("stall_sat", DW'(stall_cnt), 70'hFFFF);
        flush = 1'b1;
        exp_q.delete();
        step();
        flush = 1'b0;
        chk("stall_flush", DW'(stall_cnt), 70'hFFFF);
        reset = 1'b1;
        #1;
        chk("stall_rst", DW'(stall_cnt), 0);
        step();
        reset = 1'b0;
`endif

        chk("queue_empty", DW'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 70, payload width in bits (regwrite + pc + wbdata + wbadd).
REQ-002 SHALL have parameter ZERO_ON_EMPTY, default 1; when 1, out_data is all-zero whenever out_valid=0.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port flush, input, 1: synchronous discard of all held entries.
REQ-006 SHALL have port in_valid, input, 1: upstream entry offered.
REQ-007 SHALL have port in_ready, output, 1: block accepts an entry this cycle.
REQ-008 SHALL have port in_data, input, DATA_W: upstream payload.
REQ-009 SHALL have port out_valid, output, 1: head entry presented downstream.
REQ-010 SHALL have port out_ready, input, 1: downstream consumes head this cycle.
REQ-011 SHALL have port out_data, output, DATA_W: head payload.
REQ-012 SHALL have port occupancy, output, 2: entries held (0..2).

Function
REQ-013 SHALL hold a main register (head) and a skid register; states EMPTY=0, ONE=1, FULL=2; occupancy equals the state encoding.
REQ-014 SHALL drive in_ready = (state != FULL) and out_valid = (state != EMPTY), both decoded from registered state only; no combinational out_ready->in_ready path.
REQ-015 SHALL define accept = in_valid & in_ready and pop = out_valid & out_ready, both evaluated at the same edge.
REQ-016 EMPTY: accept -> ONE, main <= in_data; otherwise stay.
REQ-017 ONE: accept & pop -> ONE, main <= in_data; accept & !pop -> FULL, skid <= in_data; pop & !accept -> EMPTY; neither -> stay.
REQ-018 FULL: pop -> ONE, main <= skid; in_valid ignored (in_ready=0); otherwise stay.
REQ-019 SHALL deliver entries in acceptance order; latency in->out is exactly one cycle when empty.
REQ-020 flush SHALL take priority over accept and pop: next state EMPTY, main and skid zeroed, same-cycle in_data discarded.
REQ-021 With ZERO_ON_EMPTY=1, main SHALL be zeroed on any transition into EMPTY; the skid register SHALL be zeroed when it drains.
REQ-022 out_data SHALL equal main at all times.

Reset
REQ-023 While reset is high: state EMPTY, main and skid all-zero, occupancy=0, out_valid=0, in_ready=1; takes effect without a clock edge.
REQ-024 Reset mid-operation SHALL discard all held entries; the first edge after deassertion behaves as EMPTY.
REQ-025 Producers SHALL NOT assert in_valid while reset is high; the block makes no guarantee about such entries.

Configuration
REQ-026 Macro PIPE_SKID_STALL_CNT_EN SHALL, when defined, add output stall_cnt [STALL_CNT_W-1:0]; it increments each cycle out_valid & !out_ready, saturates at all-ones, clears only on reset (not flush).
REQ-027 Without PIPE_SKID_STALL_CNT_EN the port and counter SHALL be absent; all other behaviour is unchanged.

Structure
REQ-028 Shared package pipe_pkg SHALL hold typedef pipe_state_t (EMPTY/ONE/FULL, 2 bits) and constant STALL_CNT_W = 16.
REQ-029 SHALL be a single module with no sub-modules; the pipeline top instantiates one per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

Verification
REQ-030 Reset, then in_valid=1, in_data=70'h5, out_ready=1 for one cycle -> next cycle out_valid=1, out_data=70'h5, occupancy=1; following cycle occupancy=0, out_data=0.
REQ-031 out_ready=0; push A=1, B=2 on consecutive cycles -> occupancy=2, in_ready=0; a third push C=3 is not accepted; raise out_ready -> outputs A, then B, then EMPTY.
REQ-032 FULL with A,B; assert flush and in_valid(C=9) together -> next cycle occupancy=0, out_valid=0, out_data=0; C never appears.
REQ-033 Streaming in_valid=out_ready=1 with data 1..100 -> out_data 1..100 in order, one per cycle, occupancy constantly 1.
REQ-034 Assert reset asynchronously between edges while FULL -> out_valid, occupancy, out_data drop to 0 before next edge; in_ready=1.
REQ-035 With PIPE_SKID_STALL_CNT_EN, hold out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF; flush leaves it unchanged; reset clears it to 0.
